// File: rtl/sample_uart_framer_pkg.sv
// Shared constants, state encodings and ASCII helpers for the sample UART framer.
package sample_uart_framer_pkg;

   // Axis encodings as produced by the upstream axis data router
   localparam logic [1:0] AXIS_X = 2'd0;
   localparam logic [1:0] AXIS_Y = 2'd1;
   localparam logic [1:0] AXIS_Z = 2'd2;

   // ASCII characters used in a frame
   localparam logic [7:0] ASCII_X     = 8'h58;
   localparam logic [7:0] ASCII_Y     = 8'h59;
   localparam logic [7:0] ASCII_Z     = 8'h5A;
   localparam logic [7:0] ASCII_QMARK = 8'h3F;
   localparam logic [7:0] ASCII_EQ    = 8'h3D;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;

   // Bytes per frame: tag, '=', four hex digits, CR, LF
   localparam int FRAME_BYTES = 8;

   // Byte transmitter states; each non-idle state lasts one bit time
   // (DATA is revisited eight times)
   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   // Framer states
   typedef enum logic {
      FR_IDLE = 1'b0,
      FR_SEND = 1'b1
   } fr_state_t;

   // Uppercase ASCII hex digit for a nibble: 0-9 -> '0'-'9', A-F -> 'A'-'F'
   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   // Axis tag character; the unused code 3 is shown as '?'
   function automatic logic [7:0] axis_tag(input logic [1:0] a);
      logic [7:0] t;
      case (a)
         AXIS_X:  t = ASCII_X;
         AXIS_Y:  t = ASCII_Y;
         AXIS_Z:  t = ASCII_Z;
         default: t = ASCII_QMARK;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/sample_uart_framer_if.sv
// Sample-in / UART-out bundle of the framer, plus FSM state visibility.
//
// Handshake: load is a one-cycle valid pulse qualified by !busy. A load
// seen while busy is high (including the final stop-bit cycle of a frame)
// is not accepted: the sample is dropped and overrun latches high. busy
// acts as the inverse of ready and is registered.
interface sample_uart_framer_if;
   import sample_uart_framer_pkg::*;

   logic        load;
   logic [15:0] data;
   logic [1:0]  axis_sel;
   logic        tx;
   logic        busy;
   logic        overrun;
   fr_state_t   fr_state;
   tx_state_t   tx_state;

   modport master (
      output load, data, axis_sel,
      input  tx, busy, overrun, fr_state, tx_state
   );

   modport slave (
      input  load, data, axis_sel,
      output tx, busy, overrun, fr_state, tx_state
   );
endinterface

// File: rtl/sample_uart_framer_uart_byte_tx.sv
// 8N1 byte transmitter. A start pulse begins a byte; byte_in is read live
// during the DATA bits and must stay stable for the whole byte. done pulses
// in the last cycle of the stop bit, and a start in that same cycle chains
// straight into the next start bit with no idle gap.
module uart_byte_tx
   import sample_uart_framer_pkg::*;
#(
   parameter int BAUD_DIV = 868   // cycles per bit, at least 2
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      start,
   input  logic [7:0] byte_in,
   output logic      tx,
   output logic      done,
   output tx_state_t state_dbg
);

   localparam int            CW       = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

   tx_state_t     state, state_nx;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx, bit_nx;
   logic          tx_q, tx_nx;
   logic          bit_end;

   assign bit_end = (cnt == CNT_LAST);

   // State register, baud/bit counters and the registered line output
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= TX_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         tx_q    <= 1'b1;
      end else begin
         state   <= state_nx;
         bit_idx <= bit_nx;
         tx_q    <= tx_nx;
         if (state == TX_IDLE || bit_end) cnt <= '0;
         else                             cnt <= cnt + 1'b1;
      end
   end

   // Next-state: advance at the end of each bit time
   always_comb begin
      state_nx = state;
      case (state)
         TX_IDLE:  if (start) state_nx = TX_START;
         TX_START: if (bit_end) state_nx = TX_DATA;
         TX_DATA:  if (bit_end && bit_idx == 3'd7) state_nx = TX_STOP;
         TX_STOP:  if (bit_end) state_nx = start ? TX_START : TX_IDLE;
         default:  state_nx = TX_IDLE;
      endcase
   end

   // Outputs: next line level (registered above), bit index and done pulse
   always_comb begin
      bit_nx = 3'd0;
      tx_nx  = 1'b1;
      done   = 1'b0;
      if (state == TX_DATA) bit_nx = bit_end ? (bit_idx + 3'd1) : bit_idx;
      case (state_nx)
         TX_START: tx_nx = 1'b0;
         TX_DATA:  tx_nx = byte_in[bit_nx];
         default:  tx_nx = 1'b1;
      endcase
      if (state == TX_STOP && bit_end) done = 1'b1;
   end

   assign tx        = tx_q;
   assign state_dbg = state;

endmodule

// File: rtl/sample_uart_framer.sv
// Captures a routed axis sample on load and sends it as an 8-byte ASCII
// frame "<tag>=HHHH\r\n" over the UART line.
module sample_uart_framer
   import sample_uart_framer_pkg::*;
#(
   parameter int BAUD_DIV = 868   // cycles per UART bit, at least 2
) (
   input  logic                 clk,
   input  logic                 reset,
   sample_uart_framer_if.slave  bus
);

   localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

   fr_state_t   state, state_nx;
   logic [15:0] data_q;
   logic [1:0]  axis_q;
   logic [2:0]  idx;
   logic        overrun_q;
   logic        accept;
   logic        last_byte;
   logic        busy;
   logic        tx_start;
   logic        tx_done;
   logic [7:0]  byte_cur;
   logic        tx_line;
   tx_state_t   tx_state;

   assign last_byte = (idx == LAST_IDX);

   // Framer state register
   always_ff @(posedge clk) begin
      if (reset) state <= FR_IDLE;
      else       state <= state_nx;
   end

   // Sample latch, byte index and sticky overrun flag
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q    <= '0;
         axis_q    <= '0;
         idx       <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (accept) begin
            data_q <= bus.data;
            axis_q <= bus.axis_sel;
            idx    <= '0;
         end else if (state == FR_SEND && tx_done && !last_byte) begin
            idx <= idx + 3'd1;
         end
         if (bus.load && busy) overrun_q <= 1'b1;
      end
   end

   // Next-state: start on an accepted load, finish after the last byte
   always_comb begin
      state_nx = state;
      case (state)
         FR_IDLE: if (bus.load) state_nx = FR_SEND;
         FR_SEND: if (tx_done && last_byte) state_nx = FR_IDLE;
         default: state_nx = FR_IDLE;
      endcase
   end

   // Outputs: busy/accept, byte-start requests and the frame byte mux.
   // The first start is issued together with the accept so the start bit
   // appears one cycle after load; later starts chain off done.
   always_comb begin
      busy     = (state == FR_SEND);
      accept   = (state == FR_IDLE) && bus.load;
      tx_start = accept || (state == FR_SEND && tx_done && !last_byte);
      byte_cur = ASCII_LF;
      case (idx)
         3'd0:    byte_cur = axis_tag(axis_q);
         3'd1:    byte_cur = ASCII_EQ;
         3'd2:    byte_cur = hex_ascii(data_q[15:12]);
         3'd3:    byte_cur = hex_ascii(data_q[11:8]);
         3'd4:    byte_cur = hex_ascii(data_q[7:4]);
         3'd5:    byte_cur = hex_ascii(data_q[3:0]);
         3'd6:    byte_cur = ASCII_CR;
         default: byte_cur = ASCII_LF;
      endcase
   end

   uart_byte_tx #(.BAUD_DIV(BAUD_DIV)) u_byte_tx (
      .clk       (clk),
      .reset     (reset),
      .start     (tx_start),
      .byte_in   (byte_cur),
      .tx        (tx_line),
      .done      (tx_done),
      .state_dbg (tx_state)
   );

   assign bus.tx       = tx_line;
   assign bus.busy     = busy;
   assign bus.overrun  = overrun_q;
   assign bus.fr_state = state;
   assign bus.tx_state = tx_state;

endmodule

// File: doc/sample_uart_framer.md
# sample_uart_framer

Streams each accelerometer axis sample to a host over a UART line as a fixed 8-byte ASCII frame. It sits directly downstream of the axis data router: it captures the routed 16-bit sample on the router's load pulse and drives the board's `Tx_Out` pin. It formats the sample as an axis tag plus four uppercase hex digits, so no division is needed. A host terminal then receives a readable log alongside the seven-segment display.

## Interface
- `BAUD_DIV`, default 868: clock cycles per UART bit (100 MHz / 115200, truncated); must be ≥ 2.
- `clk`  in  1: system clock; everything is synchronous to the rising edge.
- `reset`  in  1: synchronous, active-high.
- `load`  in  1: one-cycle pulse; a new sample is valid on `data` and `axis_sel`.
- `data`  in  16: raw two's-complement axis sample, transmitted as-is.
- `axis_sel`  in  2: 0 = X, 1 = Y, 2 = Z, 3 = invalid.
- `tx`  out  1: UART line, 8N1, LSB first, idles high.
- `busy`  out  1: high while a frame is being transmitted.
- `overrun`  out  1: sticky; set when `load` arrives while `busy`; cleared only by `reset`.

## Operation
- Frame is 8 bytes: tag, `=` (0x3D), hex digits of `data[15:12]`, `[11:8]`, `[7:4]`, `[3:0]`, CR (0x0D), LF (0x0A).
- Tag is `X` (0x58), `Y` (0x59), `Z` (0x5A), or `?` (0x3F) when `axis_sel` is 3.
- Hex digit mapping: 0–9 → 0x30–0x39; A–F → 0x41–0x46.
- `data` and `axis_sel` are latched on the accepting `load` edge. Later input changes do not affect the frame in flight.
- Framer FSM:
  - IDLE: on `load`, latch the inputs, set byte index to 0, go to SEND.
  - SEND: present byte[index] to the byte transmitter and wait for its `done`.
  - On `done`: if index = 7, go to IDLE; otherwise increment index and stay in SEND.
- Byte transmitter FSM (START, DATA×8, STOP): each state lasts exactly `BAUD_DIV` cycles. The bit counter is 3 bits; the baud counter is ceil(log2(`BAUD_DIV`)) bits.
- `load` while `busy`: the sample is dropped, `overrun` is set, and the frame in flight is unchanged.
- `load` in the same cycle that the last stop bit ends: the sample is dropped and `overrun` is set, because `busy` is still high in that cycle.
- `reset`, including mid-frame: all counters clear and both FSMs return to IDLE.

## Timing
- Reset values: `tx` = 1, `busy` = 0, `overrun` = 0.
- `load` accepted at edge N:
  - `busy` = 1 and `tx` = 0 (start bit) from edge N+1.
- Each bit is held for exactly `BAUD_DIV` cycles.
- There are no gaps between bytes: the stop bit of byte k is followed immediately by the start bit of byte k+1.
- Frame length is 80 × `BAUD_DIV` cycles. `busy` falls at edge N+1+80×`BAUD_DIV`, and `tx` is then 1.
- The earliest next accepted `load` is at the edge where `busy` reads 0.
- `reset` asserted at edge M: `tx` = 1 and `busy` = 0 from edge M+1. A partially sent byte is truncated; the line is left high.
- `tx` is driven directly from a register, so there is no combinational path from the inputs to `tx`.

## Structure
- Shared package holds:
  - axis encodings: AXIS_X = 0, AXIS_Y = 1, AXIS_Z = 2;
  - ASCII constants: tags, `=`, CR, LF, `?`;
  - frame length: FRAME_BYTES = 8;
  - byte-transmitter state enum.
- Sub-module `uart_byte_tx` (parameter `BAUD_DIV`):
  - inputs: `clk`, `reset`, `start`, `byte_in[7:0]`;
  - outputs: `tx`, `done` (one-cycle pulse in the last cycle of the stop bit).
- The framer owns the latch registers, byte index, byte mux and hex encoder.

## Test plan
- Use `BAUD_DIV` = 4 for simulation. The bench's UART receive model samples at mid-bit.
- Reset: hold `reset` for 3 cycles → `tx` = 1, `busy` = 0, `overrun` = 0; no edges on `tx` for 100 cycles.
- `load` with `axis_sel` = 0, `data` = 0x01A3 → bytes 58 3D 30 31 41 33 0D 0A; `busy` high for exactly 320 cycles; each bit lasts 4 cycles.
- `axis_sel` = 2, `data` = 0xFF00, immediately followed by `axis_sel` = 3, `data` = 0x7FFF once idle:
  - first frame 5A 3D 46 46 30 30 0D 0A;
  - second frame 3F 3D 37 46 46 46 0D 0A;
  - no idle gap longer than 1 cycle between frames.
- Second `load` 50 cycles into a frame, with `data` changed at the same time → original frame is unaltered, `overrun` = 1, and it stays 1 after the frame ends.
- `reset` at cycle 130 of a frame → `tx` = 1 and `busy` = 0 on the next cycle; a following `load` of 0x0000 on Y gives 59 3D 30 30 30 30 0D 0A.
